// File: rtl/inst_buffer_if.sv
`default_nettype none
// ============================================================================
// inst_buffer_if : fetch/decode-side bundle of the dual-issue instruction buffer
// Revision 1.0
// ============================================================================
interface inst_buffer_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    parameter int EXC_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             fetch_valid1;
    logic             fetch_valid2;
    logic [AW-1:0]    fetch_inst1;
    logic [AW-1:0]    fetch_inst2;
    logic [AW-1:0]    fetch_addr1;
    logic [AW-1:0]    fetch_addr2;
    logic [EXC_W-1:0] fetch_exccode1;
    logic [EXC_W-1:0] fetch_exccode2;
    logic             buf_full;
    logic [1:0]       issue_cnt;
    logic [AW-1:0]    inst1;
    logic [AW-1:0]    iaddr1;
    logic [EXC_W-1:0] exccode1;
    logic             valid1;
    logic [AW-1:0]    inst2;
    logic [AW-1:0]    iaddr2;
    logic [EXC_W-1:0] exccode2;
    logic             valid2;
    logic [CW-1:0]    count;

    modport master (
        output flush, fetch_valid1, fetch_valid2, fetch_inst1, fetch_inst2,
               fetch_addr1, fetch_addr2, fetch_exccode1, fetch_exccode2, issue_cnt,
        input  buf_full, inst1, iaddr1, exccode1, valid1,
               inst2, iaddr2, exccode2, valid2, count
    );

    modport slave (
        input  flush, fetch_valid1, fetch_valid2, fetch_inst1, fetch_inst2,
               fetch_addr1, fetch_addr2, fetch_exccode1, fetch_exccode2, issue_cnt,
        output buf_full, inst1, iaddr1, exccode1, valid1,
               inst2, iaddr2, exccode2, valid2, count
    );
endinterface
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// inst_buffer : dual-write / dual-read circular instruction FIFO for dual decode
// Revision 1.0
// ============================================================================
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 32,
    parameter int EXC_W = 5
) (
    input  wire logic     clk,
    input  wire logic     reset,
    inst_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [AW-1:0]    inst_mem_q [DEPTH];
    logic [AW-1:0]    addr_mem_q [DEPTH];
    logic [EXC_W-1:0] exc_mem_q  [DEPTH];

    logic             full;
    logic             wr1, wr2;
    logic [1:0]       wr_n, rd_n, issue_clamp;
    logic [PW-1:0]    head_p1, tail_p1;
    logic             v1, v2;

    always_comb begin
        full        = (count_q > CW'(DEPTH - 2));
        // Acceptance uses the pre-edge occupancy; flush discards the offer.
        wr1         = bus.fetch_valid1 && !full && !bus.flush;
        wr2         = wr1 && bus.fetch_valid2;
        wr_n        = {1'b0, wr1} + {1'b0, wr2};
        issue_clamp = (bus.issue_cnt == 2'd3) ? 2'd2 : bus.issue_cnt;
        rd_n        = (CW'(issue_clamp) > count_q) ? count_q[1:0] : issue_clamp;
        head_p1     = head_q + PW'(1);
        tail_p1     = tail_q + PW'(1);

        head_d  = head_q + PW'(rd_n);
        tail_d  = tail_q + PW'(wr_n);
        count_d = count_q + CW'(wr_n) - CW'(rd_n);
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (wr1) begin
            inst_mem_q[tail_q] <= bus.fetch_inst1;
            addr_mem_q[tail_q] <= bus.fetch_addr1;
            exc_mem_q[tail_q]  <= bus.fetch_exccode1;
        end
        if (wr2) begin
            inst_mem_q[tail_p1] <= bus.fetch_inst2;
            addr_mem_q[tail_p1] <= bus.fetch_addr2;
            exc_mem_q[tail_p1]  <= bus.fetch_exccode2;
        end
    end

    assign v1 = (count_q != '0);
    assign v2 = (count_q >= CW'(2));

    assign bus.buf_full = full;
    assign bus.count    = count_q;
    assign bus.valid1   = v1;
    assign bus.valid2   = v2;
    assign bus.inst1    = v1 ? inst_mem_q[head_q]  : '0;
    assign bus.iaddr1   = v1 ? addr_mem_q[head_q]  : '0;
    assign bus.exccode1 = v1 ? exc_mem_q[head_q]   : '0;
    assign bus.inst2    = v2 ? inst_mem_q[head_p1] : '0;
    assign bus.iaddr2   = v2 ? addr_mem_q[head_p1] : '0;
    assign bus.exccode2 = v2 ? exc_mem_q[head_p1]  : '0;
endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// tb_inst_buffer : randomized bench checking inst_buffer against a queue model
// Revision 1.0
// ============================================================================
module tb_inst_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int EW    = 5;

    typedef struct packed {
        logic [AW-1:0] inst;
        logic [AW-1:0] addr;
        logic [EW-1:0] exc;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    entry_t model_q[$];
    logic [AW-1:0] pc;

    always #5 clk = ~clk;

    inst_buffer_if #(.DEPTH(DEPTH), .AW(AW), .EXC_W(EW)) bif ();

    inst_buffer #(.DEPTH(DEPTH), .AW(AW), .EXC_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: pop the oldest rd entries, then append accepted writes.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_q.delete();
        end else if (bif.flush) begin
            model_q.delete();
        end else begin
            int  sz;
            int  rd;
            bit  acc;
            sz  = model_q.size();
            acc = (sz <= DEPTH - 2);
            rd  = (bif.issue_cnt > 2) ? 2 : int'(bif.issue_cnt);
            if (rd > sz) rd = sz;
            for (int k = 0; k < rd; k++) void'(model_q.pop_front());
            if (acc && bif.fetch_valid1) begin
                model_q.push_back('{bif.fetch_inst1, bif.fetch_addr1, bif.fetch_exccode1});
                if (bif.fetch_valid2)
                    model_q.push_back('{bif.fetch_inst2, bif.fetch_addr2, bif.fetch_exccode2});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            entry_t e1, e2;
            int     sz;
            sz = model_q.size();
            e1 = (sz >= 1) ? model_q[0] : '0;
            e2 = (sz >= 2) ? model_q[1] : '0;
            chk("count",    64'(bif.count),    64'(sz));
            chk("buf_full", 64'(bif.buf_full), 64'(sz >= DEPTH - 1));
            chk("valid1",   64'(bif.valid1),   64'(sz >= 1));
            chk("valid2",   64'(bif.valid2),   64'(sz >= 2));
            chk("inst1",    64'(bif.inst1),    64'(e1.inst));
            chk("iaddr1",   64'(bif.iaddr1),   64'(e1.addr));
            chk("exccode1", 64'(bif.exccode1), 64'(e1.exc));
            chk("inst2",    64'(bif.inst2),    64'(e2.inst));
            chk("iaddr2",   64'(bif.iaddr2),   64'(e2.addr));
            chk("exccode2", 64'(bif.exccode2), 64'(e2.exc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of stimulus; pc advances only for writes the buffer will take.
    task automatic drive(input bit v1, input bit v2, input logic [1:0] iss,
                         input bit fl, input logic [EW-1:0] ex1);
        bit acc;
        acc = v1 && !fl && (model_q.size() <= DEPTH - 2);
        bif.fetch_valid1   = v1;
        bif.fetch_valid2   = v2;
        bif.fetch_inst1    = $urandom;
        bif.fetch_inst2    = $urandom;
        bif.fetch_addr1    = pc;
        bif.fetch_addr2    = pc + 4;
        bif.fetch_exccode1 = ex1;
        bif.fetch_exccode2 = EW'($urandom_range(0, 3));
        bif.issue_cnt      = iss;
        bif.flush          = fl;
        if (acc) pc = pc + (v2 ? 8 : 4);
        cyc();
    endtask

    initial begin
        logic [AW-1:0] last;
        int            n;
        pc = 32'hBFC00000;
        bif.flush = 0; bif.fetch_valid1 = 0; bif.fetch_valid2 = 0;
        bif.fetch_inst1 = '0; bif.fetch_inst2 = '0;
        bif.fetch_addr1 = '0; bif.fetch_addr2 = '0;
        bif.fetch_exccode1 = '0; bif.fetch_exccode2 = '0;
        bif.issue_cnt = 2'd0;
        repeat (2) cyc();
        chk("reset_count", 64'(bif.count), 64'd0);
        chk("reset_valid1", 64'(bif.valid1), 64'd0);
        chk("reset_full", 64'(bif.buf_full), 64'd0);
        reset = 1'b0;

        // First pair
        bif.fetch_valid1 = 1; bif.fetch_valid2 = 1;
        bif.fetch_inst1 = 32'h24010001; bif.fetch_addr1 = 32'hBFC00000;
        bif.fetch_inst2 = 32'h24020002; bif.fetch_addr2 = 32'hBFC00004;
        pc = 32'hBFC00008;
        cyc();
        bif.fetch_valid1 = 0; bif.fetch_valid2 = 0;
        chk("pair_inst1", 64'(bif.inst1), 64'h24010001);
        chk("pair_iaddr2", 64'(bif.iaddr2), 64'hBFC00004);
        chk("pair_count", 64'(bif.count), 64'd2);
        chk("pair_valid2", 64'(bif.valid2), 64'd1);

        // Fill to 15, dropped write, then retire two
        drive(1, 0, 2'd0, 0, '0);
        n = 0;
        while (model_q.size() <= DEPTH - 2 && n < 20) begin
            drive(1, 1, 2'd0, 0, '0);
            n++;
        end
        chk("fill_count", 64'(bif.count), 64'd15);
        chk("fill_full", 64'(bif.buf_full), 64'd1);
        drive(1, 1, 2'd0, 0, '0);
        chk("drop_count", 64'(bif.count), 64'd15);
        drive(0, 0, 2'd2, 0, '0);
        chk("retire_count", 64'(bif.count), 64'd13);
        chk("retire_full", 64'(bif.buf_full), 64'd0);

        // Drain, then steady state across pointer wrap
        n = 0;
        while (model_q.size() > 0 && n < 20) begin
            drive(0, 0, 2'd3, 0, '0);
            n++;
        end
        drive(1, 1, 2'd0, 0, '0);
        last = bif.iaddr1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 2'd2, 0, '0);
            chk("steady_count", 64'(bif.count), 64'd2);
            chk("steady_pc", 64'(bif.iaddr1), 64'(last + 8));
            last = bif.iaddr1;
        end

        // Over-consume from count=1
        drive(0, 0, 2'd1, 0, '0);
        chk("one_count", 64'(bif.count), 64'd1);
        drive(0, 0, 2'd2, 0, '0);
        chk("under_count", 64'(bif.count), 64'd0);
        chk("under_valid1", 64'(bif.valid1), 64'd0);
        chk("under_inst1", 64'(bif.inst1), 64'd0);

        // Flush with a concurrent write and read
        repeat (3) drive(1, 1, 2'd0, 0, '0);
        chk("pre_flush_count", 64'(bif.count), 64'd6);
        drive(1, 1, 2'd2, 1, '0);
        chk("flush_count", 64'(bif.count), 64'd0);
        chk("flush_valid1", 64'(bif.valid1), 64'd0);
        last = pc;
        drive(1, 0, 2'd0, 0, '0);
        chk("post_flush_pc", 64'(bif.iaddr1), 64'(last));

        // Exception code reaches head
        drive(1, 0, 2'd1, 0, 5'h04);
        chk("exc_head", 64'(bif.exccode1), 64'h04);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit v1, v2, fl;
            v1 = ($urandom_range(0, 3) != 0);
            v2 = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 40) == 0);
            drive(v1, v2, 2'($urandom_range(0, 3)), fl, EW'($urandom_range(0, 1) * $urandom_range(0, 31)));
        end

        // Asynchronous reset mid-stream
        repeat (4) drive(1, 1, 2'd0, 0, '0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_valid1", 64'(bif.valid1), 64'd0);
        chk("async_valid2", 64'(bif.valid2), 64'd0);
        chk("async_count", 64'(bif.count), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 30; i++)
            drive(1, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
